// File: rtl/jelly_vout_axi4s_pkg.sv
// Shared definitions for jelly_vout_axi4s: the lock FSM state type and the
// width of the optional error counter.
package jelly_vout_axi4s_pkg;

  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    WAIT_FS = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/jelly_vout_axi4s_errcnt.sv
// Saturating error counter for jelly_vout_axi4s.
// Adds up to two events per cycle and sticks at all-ones.
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset, clears the count
//   inc_a_i   event A (+1)
//   inc_b_i   event B (+1)
//   count_o   current count
module jelly_vout_axi4s_errcnt
  import jelly_vout_axi4s_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 inc_a_i,
  input  logic                 inc_b_i,
  output logic [ERR_CNT_W-1:0] count_o
);

  logic [ERR_CNT_W-1:0] count_q, count_d;
  logic [ERR_CNT_W:0]   sum;

  always_comb begin
    sum = {1'b0, count_q}
        + {{ERR_CNT_W{1'b0}}, inc_a_i}
        + {{ERR_CNT_W{1'b0}}, inc_b_i};
    count_d = sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/jelly_vout_axi4s.sv
// AXI4-Stream to video-timing output. Locks an incoming pixel stream to a
// reference vsync/hsync/de timing and emits one pixel per de cycle.
// Optional feature: define JELLY_VOUT_AXI4S_ERR_COUNT_EN to build the
// saturating error counter; otherwise err_count is tied to zero.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_vsync/in_hsync/in_de/in_ctl    reference timing and sideband
//   s_axi4s_*                         pixel stream (tuser = frame start)
//   out_vsync/out_hsync/out_de/out_ctl  timing delayed one cycle
//   out_data                          pixel aligned to out_de (0 if none)
//   out_locked                        high while in RUN
//   out_underflow                     pulse per starved pixel
//   err_count                         underflow + resync event count
module jelly_vout_axi4s
  import jelly_vout_axi4s_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vsync,
  input  logic                 in_hsync,
  input  logic                 in_de,
  input  logic [3:0]           in_ctl,
  input  logic                 s_axi4s_tuser,
  input  logic                 s_axi4s_tlast,
  input  logic [WIDTH-1:0]     s_axi4s_tdata,
  input  logic                 s_axi4s_tvalid,
  output logic                 s_axi4s_tready,
  output logic                 out_vsync,
  output logic                 out_hsync,
  output logic                 out_de,
  output logic [WIDTH-1:0]     out_data,
  output logic [3:0]           out_ctl,
  output logic                 out_locked,
  output logic                 out_underflow,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t           state_q, state_d;
  logic             vsync_prev_q;
  logic             first_q, first_d;
  logic             frame_start;
  logic             resync;
  logic             underflow_d;
  logic [WIDTH-1:0] data_d;

  logic             vsync_q, hsync_q, de_q, underflow_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] data_q;

  // Line length is driven purely by in_de; tlast carries no control meaning.
  logic unused_tlast;
  assign unused_tlast = s_axi4s_tlast;

  assign frame_start = in_vsync & ~vsync_prev_q;

  // first_q marks that no de cycle has happened yet in the current frame,
  // i.e. the next pixel is the only one allowed to carry tuser.
  always_comb begin
    state_d        = state_q;
    first_d        = first_q;
    s_axi4s_tready = 1'b0;
    resync         = 1'b0;
    underflow_d    = 1'b0;

    case (state_q)
      SEARCH: begin
        s_axi4s_tready = s_axi4s_tvalid & ~s_axi4s_tuser;
        if (s_axi4s_tvalid && s_axi4s_tuser) begin
          state_d = WAIT_FS;
        end
      end

      WAIT_FS: begin
        if (frame_start) begin
          state_d = RUN;
          first_d = 1'b1;
        end
      end

      RUN: begin
        if (frame_start) begin
          if (s_axi4s_tvalid && s_axi4s_tuser) begin
            first_d = 1'b1;
          end else begin
            state_d = SEARCH;
            resync  = 1'b1;
          end
        end
        if (!resync && in_de) begin
          if (s_axi4s_tvalid && s_axi4s_tuser && !first_d) begin
            // Mid-frame frame-start beat: leave it pending for the next frame.
            state_d = WAIT_FS;
            resync  = 1'b1;
          end else begin
            s_axi4s_tready = 1'b1;
            underflow_d    = ~s_axi4s_tvalid;
          end
          first_d = 1'b0;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase

    if (reset) begin
      s_axi4s_tready = 1'b0;
    end
  end

  always_comb begin
    data_d = '0;
    if (state_q == RUN && s_axi4s_tready && s_axi4s_tvalid) begin
      data_d = s_axi4s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEARCH;
      vsync_prev_q <= in_vsync;
      first_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      de_q         <= 1'b0;
      ctl_q        <= '0;
      data_q       <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= in_vsync;
      first_q      <= first_d;
      vsync_q      <= in_vsync;
      hsync_q      <= in_hsync;
      de_q         <= in_de;
      ctl_q        <= in_ctl;
      data_q       <= data_d;
      underflow_q  <= underflow_d;
    end
  end

  assign out_vsync     = vsync_q;
  assign out_hsync     = hsync_q;
  assign out_de        = de_q;
  assign out_ctl       = ctl_q;
  assign out_data      = data_q;
  assign out_underflow = underflow_q;
  assign out_locked    = (state_q == RUN);

`ifdef JELLY_VOUT_AXI4S_ERR_COUNT_EN
  jelly_vout_axi4s_errcnt u_errcnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_a_i (underflow_d),
    .inc_b_i (resync),
    .count_o (err_count)
  );
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_jelly_vout_axi4s.sv
module tb_jelly_vout_axi4s;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vsync, in_hsync, in_de;
  logic [3:0]  in_ctl;
  logic        s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tvalid, s_axi4s_tready;
  logic [23:0] s_axi4s_tdata;
  logic        out_vsync, out_hsync, out_de, out_locked, out_underflow;
  logic [23:0] out_data;
  logic [3:0]  out_ctl;
  logic [15:0] err_count;

  jelly_vout_axi4s #(.WIDTH(24)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_vsync       (in_vsync),
    .in_hsync       (in_hsync),
    .in_de          (in_de),
    .in_ctl         (in_ctl),
    .s_axi4s_tuser  (s_axi4s_tuser),
    .s_axi4s_tlast  (s_axi4s_tlast),
    .s_axi4s_tdata  (s_axi4s_tdata),
    .s_axi4s_tvalid (s_axi4s_tvalid),
    .s_axi4s_tready (s_axi4s_tready),
    .out_vsync      (out_vsync),
    .out_hsync      (out_hsync),
    .out_de         (out_de),
    .out_data       (out_data),
    .out_ctl        (out_ctl),
    .out_locked     (out_locked),
    .out_underflow  (out_underflow),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        user;
    logic [23:0] data;
  } beat_t;

  beat_t       src_q[$];
  logic [24:0] exp_q[$];
  logic [23:0] outlog[$];
  logic        starve;
  int          checks = 0;
  int          errors = 0;

  logic [23:0] ep [8];
  logic [7:0]  euf_m, stv_m;

`ifdef JELLY_VOUT_AXI4S_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_src();
    s_axi4s_tvalid = (src_q.size() > 0) && !starve;
    s_axi4s_tdata  = (src_q.size() > 0) ? src_q[0].data : 24'h0;
    s_axi4s_tuser  = (src_q.size() > 0) ? src_q[0].user : 1'b0;
    s_axi4s_tlast  = 1'($urandom);
  endtask

  task automatic push_beat(input logic user, input logic [23:0] data);
    beat_t b;
    b.user = user;
    b.data = data;
    src_q.push_back(b);
    drive_src();
  endtask

  // One clock cycle: drive inputs, record the expected pixel for a de cycle,
  // and retire the stream beat if it was handed over at this edge.
  task automatic step(input logic vs, input logic de, input logic [23:0] ed,
                      input logic euf, input logic stv);
    logic take;
    in_vsync = vs;
    in_de    = de;
    in_hsync = 1'($urandom);
    in_ctl   = 4'($urandom);
    starve   = stv;
    drive_src();
    if (de && !reset) exp_q.push_back({euf, ed});
    @(negedge clk);
    take = s_axi4s_tvalid && s_axi4s_tready;
    @(posedge clk);
    #1;
    if (take) begin
      void'(src_q.pop_front());
      drive_src();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    idle(2);
  endtask

  // 4x2 frame: two lines of four pixels separated by two blank cycles.
  task automatic frame8();
    outlog.delete();
    vs_pulse();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) idle(2);
      step(1'b0, 1'b1, ep[i], euf_m[i], stv_m[i]);
    end
    idle(2);
  endtask

  // Compare process: timing outputs are the previous cycle's inputs, zero
  // after a reset cycle; every out_de cycle must match the next expected pixel.
  logic       started = 1'b0;
  logic       p_rst, p_vs, p_hs, p_de;
  logic [3:0] p_ctl;
  always @(negedge clk) begin
    logic [24:0] e;
    if (started) begin
      if (p_rst) begin
        chk("rst_vsync", {31'b0, out_vsync}, 0);
        chk("rst_hsync", {31'b0, out_hsync}, 0);
        chk("rst_de", {31'b0, out_de}, 0);
        chk("rst_ctl", {28'b0, out_ctl}, 0);
        chk("rst_data", {8'b0, out_data}, 0);
        chk("rst_underflow", {31'b0, out_underflow}, 0);
      end else begin
        chk("vsync", {31'b0, out_vsync}, {31'b0, p_vs});
        chk("hsync", {31'b0, out_hsync}, {31'b0, p_hs});
        chk("de", {31'b0, out_de}, {31'b0, p_de});
        chk("ctl", {28'b0, out_ctl}, {28'b0, p_ctl});
        if (out_de) begin
          if (exp_q.size() == 0) begin
            chk("pixel_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pixel_data", {8'b0, out_data}, {8'b0, e[23:0]});
            chk("pixel_underflow", {31'b0, out_underflow}, {31'b0, e[24]});
          end
          outlog.push_back(out_data);
        end else begin
          chk("blank_data", {8'b0, out_data}, 0);
          chk("blank_underflow", {31'b0, out_underflow}, 0);
        end
      end
    end
    p_rst   = reset;
    p_vs    = in_vsync;
    p_hs    = in_hsync;
    p_de    = in_de;
    p_ctl   = in_ctl;
    started = 1'b1;
  end

  initial begin
    reset    = 1'b1;
    in_vsync = 1'b0;
    in_hsync = 1'b0;
    in_de    = 1'b0;
    in_ctl   = 4'h0;
    starve   = 1'b0;
    drive_src();
    idle(3);
    chk("reset_locked", {31'b0, out_locked}, 0);
    chk("reset_err", {16'b0, err_count}, 0);
    chk("reset_tready", {31'b0, s_axi4s_tready}, 0);

    // Basic 4x2 frame with the stream preloaded.
    push_beat(1'b1, 24'h000100);
    for (int i = 1; i < 8; i++) push_beat(1'b0, 24'h000100 + 24'(i));
    reset = 1'b0;
    idle(3);
    chk("waitfs_tready", {31'b0, s_axi4s_tready}, 0);
    for (int i = 0; i < 8; i++) ep[i] = 24'h000100 + 24'(i);
    euf_m = 8'h00;
    stv_m = 8'h00;
    frame8();
    chk("t1_locked", {31'b0, out_locked}, 1);
    chk("t1_first_pix", {8'b0, outlog[0]}, 32'h000100);
    chk("t1_last_pix", {8'b0, outlog[7]}, 32'h000107);
    chk("t1_consumed", src_q.size(), 0);
    chk("t1_err", {16'b0, err_count}, 0);

    // Junk beats ahead of the frame-start beat are discarded while searching.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    push_beat(1'b0, 24'h0000A0);
    push_beat(1'b0, 24'h0000A1);
    push_beat(1'b0, 24'h0000A2);
    push_beat(1'b1, 24'h000200);
    for (int i = 1; i < 8; i++) push_beat(1'b0, 24'h000200 + 24'(i));
    idle(6);
    chk("t2_junk_dropped", src_q.size(), 8);
    chk("t2_locked_pre", {31'b0, out_locked}, 0);
    for (int i = 0; i < 8; i++) ep[i] = 24'h000200 + 24'(i);
    frame8();
    chk("t2_first_pix", {8'b0, outlog[0]}, 32'h000200);
    chk("t2_locked", {31'b0, out_locked}, 1);

    // Two starved pixels (indices 2 and 5).
    push_beat(1'b1, 24'h000300);
    for (int i = 1; i < 6; i++) push_beat(1'b0, 24'h000300 + 24'(i));
    ep[0] = 24'h000300; ep[1] = 24'h000301; ep[2] = 24'h0;        ep[3] = 24'h000302;
    ep[4] = 24'h000303; ep[5] = 24'h0;        ep[6] = 24'h000304; ep[7] = 24'h000305;
    euf_m = 8'b0010_0100;
    stv_m = 8'b0010_0100;
    frame8();
    chk("t3_err", {16'b0, err_count}, CNT_EN ? 32'd2 : 32'd0);
    chk("t3_consumed", src_q.size(), 0);
    chk("t3_locked", {31'b0, out_locked}, 1);
    euf_m = 8'h00;
    stv_m = 8'h00;

    // Frame-start beat arriving at pixel 5: held back for the next frame.
    push_beat(1'b1, 24'h000400);
    for (int i = 1; i < 5; i++) push_beat(1'b0, 24'h000400 + 24'(i));
    push_beat(1'b1, 24'h000500);
    for (int i = 1; i < 8; i++) push_beat(1'b0, 24'h000500 + 24'(i));
    for (int i = 0; i < 8; i++) ep[i] = (i < 5) ? 24'h000400 + 24'(i) : 24'h0;
    frame8();
    chk("t4_locked_lost", {31'b0, out_locked}, 0);
    chk("t4_beat_kept", src_q.size(), 8);
    for (int i = 0; i < 8; i++) ep[i] = 24'h000500 + 24'(i);
    frame8();
    chk("t4_relock_pix", {8'b0, outlog[0]}, 32'h000500);
    chk("t4_locked", {31'b0, out_locked}, 1);
    chk("t4_err", {16'b0, err_count}, CNT_EN ? 32'd3 : 32'd0);

    // Reset pulsed at pixel 3; relock on the next real vsync edge.
    push_beat(1'b1, 24'h000600);
    for (int i = 1; i < 8; i++) push_beat(1'b0, 24'h000600 + 24'(i));
    push_beat(1'b1, 24'h000700);
    for (int i = 1; i < 8; i++) push_beat(1'b0, 24'h000700 + 24'(i));
    vs_pulse();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'h000600 + 24'(i), 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("t5_rst_data", {8'b0, out_data}, 0);
    chk("t5_rst_de", {31'b0, out_de}, 0);
    chk("t5_rst_locked", {31'b0, out_locked}, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("t5_no_false_fs", {31'b0, out_locked}, 0);
    chk("t5_junk_dropped", src_q.size(), 8);
    idle(2);
    for (int i = 0; i < 8; i++) ep[i] = 24'h000700 + 24'(i);
    frame8();
    chk("t5_relock_pix", {8'b0, outlog[0]}, 32'h000700);
    chk("t5_locked", {31'b0, out_locked}, 1);
    chk("t5_err", {16'b0, err_count}, 0);

    // Long starvation: counter saturates.
`ifdef JELLY_VOUT_AXI4S_ERR_COUNT_EN
    force dut.u_errcnt.count_q = 16'hFFFE;
    #1;
    release dut.u_errcnt.count_q;
`endif
    idle(1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 24'h0, 1'b1, 1'b0);
    idle(2);
    chk("t6_err_sat", {16'b0, err_count}, CNT_EN ? 32'h0000FFFF : 32'd0);
    chk("t6_locked", {31'b0, out_locked}, 1);

    // Frame start in RUN with no frame-start beat pending drops back to search.
    vs_pulse();
    chk("t7_resync_unlocked", {31'b0, out_locked}, 0);
    idle(2);
    chk("exp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly_vout_axi4s.md
JELLY_VOUT_AXI4S -- requirements
Module: jelly_vout_axi4s

Interface
REQ-001 Parameter WIDTH, default 24, pixel data width in bits.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_vsync  input  1  reference vertical sync, active-high.
REQ-005 in_hsync  input  1  reference horizontal sync.
REQ-006 in_de  input  1  reference data-enable, one pixel per cycle while high.
REQ-007 in_ctl  input  4  sideband control, passed through.
REQ-008 s_axi4s_tuser  input  1  frame-start marker on first pixel.
REQ-009 s_axi4s_tlast  input  1  end of line, informational only.
REQ-010 s_axi4s_tdata  input  WIDTH  pixel data.
REQ-011 s_axi4s_tvalid  input  1  beat valid.
REQ-012 s_axi4s_tready  output  1  beat accepted when tvalid and tready are both high.
REQ-013 out_vsync, out_hsync, out_de  output  1 each  timing delayed by one cycle.
REQ-014 out_data  output  WIDTH  pixel aligned to out_de.
REQ-015 out_ctl  output  4  in_ctl delayed by one cycle.
REQ-016 out_locked  output  1  high while in RUN.
REQ-017 out_underflow  output  1  one-cycle pulse per starved pixel.
REQ-018 err_count  output  16  error counter (see Configuration).

Function
REQ-019 The block SHALL implement states SEARCH, WAIT_FS and RUN.
REQ-020 SEARCH SHALL drive tready = tvalid & !tuser, discarding beats until a tuser=1 beat is pending, then go to WAIT_FS without consuming that beat.
REQ-021 WAIT_FS SHALL hold tready=0 until a frame start (in_vsync rising edge, 0 in previous cycle and 1 now), then go to RUN.
REQ-022 RUN SHALL drive tready = in_de, combinationally, with no extra latency.
REQ-023 Only the first accepted beat of a frame SHALL carry tuser=1; a tuser=1 beat presented on any later in_de cycle SHALL NOT be consumed, SHALL cause a resync (go to WAIT_FS), and that pixel SHALL be output as 0.
REQ-024 A frame start in RUN while the pending beat has tuser=0 or tvalid=0 SHALL be a resync: go to SEARCH.
REQ-025 in_de=1 in RUN with tvalid=0 SHALL output out_data=0 and pulse out_underflow in the same cycle as out_de.
REQ-026 out_data SHALL be 0 whenever out_de=0 or the state is not RUN.
REQ-027 out_vsync, out_hsync, out_de and out_ctl SHALL be registered copies of the inputs with exactly one cycle of latency in all states.
REQ-028 out_data SHALL be the registered tdata of the beat accepted in the previous cycle.
REQ-029 tlast SHALL be ignored for control; line length follows in_de.

Reset
REQ-030 On reset: state=SEARCH, out_vsync=out_hsync=out_de=0, out_ctl=0, out_data=0, out_locked=0, out_underflow=0, err_count=0.
REQ-031 tready SHALL be 0 while reset is high, and the previous-vsync register SHALL load in_vsync so no false edge occurs at release.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the block resumes from SEARCH.

Configuration
REQ-033 With JELLY_VOUT_AXI4S_ERR_COUNT_EN defined, err_count SHALL increment, saturating at 16'hFFFF, on each underflow pulse and each resync event (+2 when both occur in one cycle).
REQ-034 Without the macro, err_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-035 Package jelly_vout_axi4s_pkg SHALL hold the state enum typedef (SEARCH/WAIT_FS/RUN) and the error-counter width constant (16).
REQ-036 The saturating counter SHALL be sub-module jelly_vout_axi4s_errcnt, instantiated only under the macro.

Verification
REQ-037 Frame 4x2, stream pre-loaded with tuser on first beat, vsync edge, then 8 de cycles -> out_data equals the 8 pixels in order, 1 cycle after in_de, no underflow, out_locked=1.
REQ-038 3 junk beats (tuser=0) before a tuser beat -> the 3 junk beats are consumed in SEARCH and the first output pixel is the tuser beat's data.
REQ-039 tvalid dropped for 2 of 8 de cycles -> 2 out_underflow pulses, those pixels output as 0, err_count=2 with the macro and 0 without.
REQ-040 tuser beat presented at pixel 5 of 8 -> beat not consumed, pixel 5 output 0, WAIT_FS entered, next frame starts with that beat.
REQ-041 Reset pulsed at pixel 3 -> all outputs are 0 the next cycle, no false frame start at release, relock on the following vsync.
REQ-042 300 starved pixels with err_count preloaded to 16'hFFFE (force) -> err_count saturates at 16'hFFFF.
